// File: rtl/microondas_pkg.sv
// Shared microwave front-panel types: key codes,
// keypad scanner states and small decode helpers.
package microondas_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'b1010;
  localparam logic [3:0] KEY_START = 4'b1011;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_RELEASE
  } scan_state_t;

  function automatic logic [3:0] row_drive(
    input logic [1:0] row
  );
    return ~(4'b0001 << row);
  endfunction

  // Bottom row carries '*', '0', '#' instead of digits.
  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    code = 4'd0;
    if (row == 2'd3) begin
      unique case (1'b1)
        (col == 2'd0): code = KEY_CLEAR;
        (col == 2'd2): code = KEY_START;
        default:       code = 4'd0;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3
           + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_bcd_scanner_if.sv
// Key-code valid/ready handshake between the
// keypad scanner and its consumers.
interface keypad_bcd_scanner_if;

  logic [3:0] bcd_out;
  logic       bcd_valid;
  logic       bcd_ready;

  modport master (
    output bcd_out,
    output bcd_valid,
    input  bcd_ready
  );

  modport slave (
    input  bcd_out,
    input  bcd_valid,
    output bcd_ready
  );

endinterface

// File: rtl/keypad_bcd_scanner_counter.sv
// Saturating stable-cycle counter shared by the
// press and release debounce phases.
module key_debounce_counter #(
  parameter int LIMIT = 1000,
  parameter int W     = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [W-1:0] CNT_SAT  = W'(LIMIT);
  localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != CNT_SAT) begin
      count <= count + 1'b1;
    end
  end

  // Asserted on the cycle whose stable sample
  // brings the count up to LIMIT.
  assign last = (count == CNT_LAST);

endmodule

// File: rtl/keypad_bcd_scanner.sv
// 4x3 keypad scanner: row scan, press/release
// debounce and BCD key code on a valid/ready port.
module keypad_bcd_scanner
  import microondas_pkg::*;
#(
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n,
  input  logic [2:0] col_n,
  keypad_bcd_scanner_if.master bcd,
  output logic       overflow,
  output logic       key_held
);

  localparam int CNT_MAX =
    (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
    SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST =
    CNT_W'(SCAN_CYCLES - 1);

  scan_state_t      state;
  logic [1:0]       row_idx;
  logic [CNT_W-1:0] dwell;
  logic [2:0]       cap_col;
  logic [2:0]       sync1;
  logic [2:0]       sync2;

  logic       pressed;
  logic       match;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_last;
  logic       one_low;
  logic [1:0] col_idx;
  logic [1:0] row_nxt;

  assign pressed = (sync2 != 3'b111);
  assign match   = (sync2 == cap_col);
  assign row_nxt = row_idx + 2'd1;

  // Ghosting or multi-key leaves more than one
  // column low; such captures are never emitted.
  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    unique case (1'b1)
      (cap_col == 3'b110): col_idx = 2'd0;
      (cap_col == 3'b101): col_idx = 2'd1;
      (cap_col == 3'b011): col_idx = 2'd2;
      default:             one_low = 1'b0;
    endcase
  end

  always_comb begin
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    unique case (1'b1)
      (state == ST_DEBOUNCE): begin
        cnt_clr = !match;
        cnt_inc = match;
      end
      (state == ST_RELEASE): begin
        cnt_clr = pressed;
        cnt_inc = !pressed;
      end
      default: ;
    endcase
  end

  key_debounce_counter #(
    .LIMIT (DEBOUNCE_CYCLES),
    .W     (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_SCAN;
      row_idx       <= 2'd0;
      row_n         <= 4'b1110;
      dwell         <= '0;
      cap_col       <= 3'b111;
      sync1         <= 3'b111;
      sync2         <= 3'b111;
      bcd.bcd_out   <= 4'd0;
      bcd.bcd_valid <= 1'b0;
      overflow      <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      sync1    <= col_n;
      sync2    <= sync1;
      overflow <= 1'b0;
      if (bcd.bcd_valid && bcd.bcd_ready) begin
        bcd.bcd_valid <= 1'b0;
      end
      case (state)
        ST_SCAN: begin
          if (dwell == SCAN_LAST) begin
            dwell <= '0;
            if (pressed) begin
              cap_col <= sync2;
              state   <= ST_DEBOUNCE;
            end else begin
              row_idx <= row_nxt;
              row_n   <= row_drive(row_nxt);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!match) begin
            state   <= ST_SCAN;
            row_idx <= row_nxt;
            row_n   <= row_drive(row_nxt);
          end else if (cnt_last) begin
            state    <= ST_EMIT;
            key_held <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (one_low) begin
            if (!bcd.bcd_valid || bcd.bcd_ready) begin
              bcd.bcd_out   <= key_code(row_idx, col_idx);
              bcd.bcd_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!pressed && cnt_last) begin
            key_held <= 1'b0;
            state    <= ST_SCAN;
            row_idx  <= 2'd0;
            row_n    <= 4'b1110;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_bcd_scanner.sv
// Directed bench for keypad_bcd_scanner with a
// behavioural 4x3 keypad model.
module tb_keypad_bcd_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic       overflow;
  logic       key_held;

  logic       key_on  = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [2:0] key_pat = 3'b111;

  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0;
  logic [3:0] acc_q[$];

  keypad_bcd_scanner_if bcd ();

  keypad_bcd_scanner #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .bcd      (bcd.master),
    .overflow (overflow),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 3'b111;
    if (key_on && !row_n[key_row]) col_n = key_pat;
  end

  always @(posedge clk) begin
    if (rst_n && bcd.bcd_valid && bcd.bcd_ready)
      acc_q.push_back(bcd.bcd_out);
    if (rst_n && overflow) ovf_cnt++;
  end

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_held(
    input logic  v,
    input string tag
  );
    int n;
    n = 0;
    while (key_held !== v && n < 200) begin
      step(1);
      n++;
    end
    check(tag, int'(key_held), int'(v));
  endtask

  task automatic press_release(
    input logic [1:0] r,
    input logic [2:0] p,
    input string      tag
  );
    key_row = r;
    key_pat = p;
    key_on  = 1'b1;
    wait_held(1'b1, {tag, "_held_up"});
    step(3);
    key_on = 1'b0;
    wait_held(1'b0, {tag, "_held_dn"});
    step(4);
  endtask

  initial begin
    int n;
    bcd.bcd_ready = 1'b1;
    step(2);
    check("rst_row_n", int'(row_n), 4'b1110);
    check("rst_bcd_out", int'(bcd.bcd_out), 0);
    check("rst_valid", int'(bcd.bcd_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_held", int'(key_held), 0);

    // '1' on row 0: DEBOUNCE entered after 4 edges
    key_row = 2'd0;
    key_pat = 3'b110;
    key_on  = 1'b1;
    rst_n   = 1'b1;
    step(6);
    check("mid_row_frozen", int'(row_n), 4'b1110);
    check("mid_held", int'(key_held), 0);
    rst_n  = 1'b0;
    key_on = 1'b0;
    #1;
    check("arst_row_n", int'(row_n), 4'b1110);
    check("arst_valid", int'(bcd.bcd_valid), 0);
    check("arst_ovf", int'(overflow), 0);
    check("arst_held", int'(key_held), 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("resume_row0", int'(row_n), 4'b1110);
    step(1);
    check("resume_row1", int'(row_n), 4'b1101);
    check("no_emit_rst", acc_q.size(), 0);

    // '5': two sync flops plus four stable cycles
    acc_q.delete();
    key_row = 2'd1;
    key_pat = 3'b101;
    key_on  = 1'b1;
    wait_held(1'b1, "k5_held_up");
    step(3);
    check("k5_held_pre", int'(key_held), 1);
    key_on = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (key_held && n < 50);
    check("k5_rel_lat", n, 6);
    step(10);
    check("k5_count", acc_q.size(), 1);
    check("k5_code", int'(acc_q[0]), 4'b0101);

    acc_q.delete();
    press_release(2'd3, 3'b110, "star");
    press_release(2'd3, 3'b011, "hash");
    check("spec_count", acc_q.size(), 2);
    check("star_code", int'(acc_q[0]), 4'b1010);
    check("hash_code", int'(acc_q[1]), 4'b1011);

    acc_q.delete();
    key_row = 2'd2;
    key_pat = 3'b101;
    for (int i = 0; i < 5; i++) begin
      key_on = 1'b1;
      step(2);
      key_on = 1'b0;
      step(2);
    end
    check("bounce_none", acc_q.size(), 0);
    check("bounce_held", int'(key_held), 0);
    press_release(2'd2, 3'b101, "k8");
    check("k8_count", acc_q.size(), 1);
    check("k8_code", int'(acc_q[0]), 4'b1000);

    acc_q.delete();
    ovf_cnt = 0;
    bcd.bcd_ready = 1'b0;
    press_release(2'd0, 3'b011, "k3");
    press_release(2'd2, 3'b110, "k7");
    check("bp_valid", int'(bcd.bcd_valid), 1);
    check("bp_code", int'(bcd.bcd_out), 4'b0011);
    check("bp_ovf", ovf_cnt, 1);
    check("bp_none", acc_q.size(), 0);
    bcd.bcd_ready = 1'b1;
    step(1);
    check("bp_drop", int'(bcd.bcd_valid), 0);
    check("bp_count", acc_q.size(), 1);
    check("bp_acc", int'(acc_q[0]), 4'b0011);

    acc_q.delete();
    ovf_cnt = 0;
    press_release(2'd2, 3'b100, "ghost");
    check("ghost_none", acc_q.size(), 0);
    check("ghost_ovf", ovf_cnt, 0);
    check("ghost_valid", int'(bcd.bcd_valid), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_bcd_scanner.md
Name: keypad_bcd_scanner

Overview:
- Upstream stage of bcd_to_binary in the microwave front panel.
- Scans the 4x3 matrix keypad (rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#) and debounces the key press and release.
- Encodes each accepted key as a 4-bit BCD code and presents it on a valid/ready handshake; the bcd_in of bcd_to_binary and the panel controller consume it.
- '*' (clear) and '#' (start) use the non-decimal codes 4'b1010 and 4'b1011.

Parameters:
- SCAN_CYCLES, 16: clock cycles each row is driven low before moving to the next row (minimum 3).
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a press or a release (minimum 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- row_n  out  4  keypad row drives, active-low, one-hot-zero; bit0 = row 1-2-3, bit3 = row *-0-#.
- col_n  in  3  keypad column sense, active-low, externally pulled up; bit0 = left column; asynchronous to clk.
- bcd_out  out  4  key code: 0-9 = digit, 4'b1010 = '*', 4'b1011 = '#'.
- bcd_valid  out  1  bcd_out holds an unconsumed key.
- bcd_ready  in  1  consumer accepts bcd_out in any cycle where bcd_valid && bcd_ready.
- overflow  out  1  one-cycle pulse when an accepted key is dropped because the output is still full.
- key_held  out  1  high from press acceptance until release acceptance.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - row_n=4'b1110, bcd_out=0, bcd_valid=0, overflow=0, key_held=0.
  - FSM=SCAN, row index=0, both counters=0, synchronizer flops=3'b111.
- Input sync: col_n passes through a 2-flop synchronizer; "pressed" means synced col != 3'b111.
- FSM states SCAN, DEBOUNCE, EMIT, RELEASE:
  - SCAN:
    - Drive the current row; the dwell counter runs 0..SCAN_CYCLES-1.
    - On the last dwell cycle: if pressed, capture row index and synced col pattern, then go to DEBOUNCE with the row frozen.
    - Otherwise advance the row index (3 wraps to 0), update row_n next cycle, and restart the dwell counter.
  - DEBOUNCE:
    - The counter increments each cycle synced col equals the captured pattern.
    - Any mismatch: return to SCAN with the next row.
    - Counter reaching DEBOUNCE_CYCLES: go to EMIT and set key_held=1.
  - EMIT (exactly one cycle):
    - Captured pattern not exactly one low bit (ghost or multi-key): no emission.
    - Otherwise code = row*3+col+1 for rows 0-2; row 3 gives col0 -> 1010, col1 -> 0000, col2 -> 1011.
    - If bcd_valid=0, or bcd_valid && bcd_ready this cycle: load bcd_out and set bcd_valid next cycle.
    - Otherwise keep the old bcd_out/bcd_valid and pulse overflow for one cycle.
    - Always proceed to RELEASE.
  - RELEASE:
    - Row stays frozen.
    - The counter increments while synced col == 3'b111 and clears otherwise.
    - Counter reaching DEBOUNCE_CYCLES: key_held=0, return to SCAN at row 0.
- Handshake:
  - bcd_valid stays high and bcd_out stays stable until a cycle with bcd_ready=1; bcd_valid drops the following cycle unless EMIT reloads it in that same cycle.
  - bcd_ready while bcd_valid=0 is ignored.
- Latency: a key held stable is presented at most 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 4 cycles after it is pressed. One emission per press, with no auto-repeat.
- Counters are wide enough for max(SCAN_CYCLES, DEBOUNCE_CYCLES) and saturate rather than wrap.
- Reset mid-operation (any state): immediately return to the reset values; a pending bcd_out is lost.

Decomposition:
- Shared package microondas_pkg:
  - key code constants KEY_CLEAR=4'b1010 and KEY_START=4'b1011, also used by the panel controller.
  - FSM state typedef.
- One natural sub-module: key_debounce_counter (stable-count with clear and terminal flag), instanced for both press and release, or shared.
- Synchronizer kept inline.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=4, bcd_ready=1 unless stated):
- Reset checks: assert rst_n=0 mid-DEBOUNCE, then release it -> row_n=1110, bcd_valid=0, overflow=0, key_held=0; scanning then resumes from row 0.
- Single digit: model holds key '5' (row1, col1) until accepted, then releases -> exactly one bcd_valid cycle with bcd_out=0101; key_held falls 4 stable cycles after release.
- Special keys: press '*', then '#' -> bcd_out=1010, then 1011. Feeding 1010 into bcd_to_binary is checked at system level.
- Bounce: '8' toggles every 2 cycles for 20 cycles, then holds -> no emission during toggling; exactly one emission of 1000 after it stabilizes.
- Backpressure: bcd_ready=0; press '3', release, press '7' -> bcd_out stays 0011 and valid; overflow pulses once for '7'. Raise bcd_ready -> valid drops the next cycle.
- Ghost: col_n=3'b100 on row 2 -> no emission, no overflow; key_held rises, then falls after release.
